// File: rtl/moving_average_filter_pkg.sv
// Shared types and helpers for the moving-average filter stage.
// Defines the window state encoding and the parameter-derived widths.
package filtro_pkg;

    typedef enum logic [1:0] {
        VAZIO,
        ENCHENDO,
        CHEIO
    } estado_t;

    localparam int unsigned LOG2_JANELA_MIN = 0;
    localparam int unsigned LOG2_JANELA_MAX = 4;

    // Running sum of N samples needs log2(N) extra bits to never overflow.
    function automatic int unsigned largura_soma(input int unsigned dw, input int unsigned l2);
        return dw + l2;
    endfunction

    // A one-entry window still needs a 1-bit pointer to index the buffer.
    function automatic int unsigned largura_ptr(input int unsigned l2);
        return (l2 > 0) ? l2 : 1;
    endfunction

endpackage

// File: rtl/moving_average_filter_if.sv
// Sample-in / average-out bus of the moving-average stage.
// The master drives samples and clear; the slave (the filter) returns the average.
interface moving_average_filter_if #(
    parameter int unsigned DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] i_dado;
    logic                  i_dado_valido;
    logic                  i_limpar;
    logic [DATA_WIDTH-1:0] o_media;
    logic                  o_media_valida;
    logic                  o_janela_cheia;

    modport master (
        output i_dado,
        output i_dado_valido,
        output i_limpar,
        input  o_media,
        input  o_media_valida,
        input  o_janela_cheia
    );

    modport slave (
        input  i_dado,
        input  i_dado_valido,
        input  i_limpar,
        output o_media,
        output o_media_valida,
        output o_janela_cheia
    );

endinterface

// File: rtl/moving_average_filter_janela_circular.sv
// Circular buffer holding the last 2^LOG2_JANELA samples.
// Exposes the entry about to be overwritten so the sum can retire it.
module janela_circular
    import filtro_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned LOG2_JANELA = 2
) (
    input  logic                  clk_fpga,
    input  logic                  reset_n,
    input  logic                  escrever,
    input  logic                  limpar,
    input  logic [DATA_WIDTH-1:0] dado,
    output logic [DATA_WIDTH-1:0] mais_antigo
);

    localparam int unsigned N    = 1 << LOG2_JANELA;
    localparam int unsigned PtrW = largura_ptr(LOG2_JANELA);

    logic [DATA_WIDTH-1:0] mem_q [N];
    logic [PtrW-1:0]       ptr_q;
    logic [PtrW-1:0]       ptr_d;

    always_comb begin
        ptr_d = (ptr_q == PtrW'(N - 1)) ? '0 : ptr_q + 1'b1;
    end

    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
            for (int i = 0; i < int'(N); i++) begin
                mem_q[i] <= '0;
            end
        end else if (limpar) begin
            ptr_q <= '0;
            for (int i = 0; i < int'(N); i++) begin
                mem_q[i] <= '0;
            end
        end else if (escrever) begin
            mem_q[ptr_q] <= dado;
            ptr_q        <= ptr_d;
        end
    end

    assign mais_antigo = mem_q[ptr_q];

endmodule

// File: rtl/moving_average_filter.sv
// Streaming moving average over the last 2^LOG2_JANELA samples.
// Stage 1 updates window, sum and fill state; stage 2 registers the average.
module moving_average_filter
    import filtro_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned LOG2_JANELA = 2
) (
    input  logic                    clk_fpga,
    input  logic                    reset_n,
    moving_average_filter_if.slave  bus
);

    localparam int unsigned N     = 1 << LOG2_JANELA;
    localparam int unsigned SomaW = largura_soma(DATA_WIDTH, LOG2_JANELA);
    localparam int unsigned CntW  = LOG2_JANELA + 1;

    if (LOG2_JANELA > LOG2_JANELA_MAX) begin : g_log2_janela_invalido
        $error("moving_average_filter: LOG2_JANELA must lie in 0..4");
    end

    logic [SomaW-1:0]      soma_q;
    logic [SomaW-1:0]      soma_d;
    logic [CntW-1:0]       cnt_q;
    logic [CntW-1:0]       cnt_d;
    estado_t               estado_q;
    estado_t               estado_d;
    logic                  s1_valido_q;
    logic                  aceita;
    logic [DATA_WIDTH-1:0] mais_antigo;

    // Clear wins over a simultaneous sample, which is dropped.
    assign aceita = bus.i_dado_valido & ~bus.i_limpar;

    janela_circular #(
        .DATA_WIDTH  (DATA_WIDTH),
        .LOG2_JANELA (LOG2_JANELA)
    ) u_janela (
        .clk_fpga    (clk_fpga),
        .reset_n     (reset_n),
        .escrever    (aceita),
        .limpar      (bus.i_limpar),
        .dado        (bus.i_dado),
        .mais_antigo (mais_antigo)
    );

    always_comb begin
        soma_d   = soma_q + SomaW'(bus.i_dado) - SomaW'(mais_antigo);
        cnt_d    = (cnt_q == CntW'(N)) ? cnt_q : cnt_q + 1'b1;
        estado_d = (cnt_d == CntW'(N)) ? CHEIO : ENCHENDO;
    end

    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            soma_q      <= '0;
            cnt_q       <= '0;
            estado_q    <= VAZIO;
            s1_valido_q <= 1'b0;
        end else if (bus.i_limpar) begin
            soma_q      <= '0;
            cnt_q       <= '0;
            estado_q    <= VAZIO;
            s1_valido_q <= 1'b0;
        end else begin
            s1_valido_q <= bus.i_dado_valido;
            if (bus.i_dado_valido) begin
                soma_q <= soma_d;
                cnt_q  <= cnt_d;
                unique case (estado_q)
                    VAZIO:    estado_q <= (N == 1) ? CHEIO : ENCHENDO;
                    ENCHENDO: estado_q <= estado_d;
                    CHEIO:    estado_q <= CHEIO;
                    default:  estado_q <= VAZIO;
                endcase
            end
        end
    end

    always_ff @(posedge clk_fpga or negedge reset_n) begin
        if (!reset_n) begin
            bus.o_media        <= '0;
            bus.o_media_valida <= 1'b0;
            bus.o_janela_cheia <= 1'b0;
        end else if (bus.i_limpar) begin
            bus.o_media        <= '0;
            bus.o_media_valida <= 1'b0;
            bus.o_janela_cheia <= 1'b0;
        end else begin
            bus.o_media_valida <= s1_valido_q;
            if (s1_valido_q) begin
                // Divide by N: keep the top DATA_WIDTH bits of the sum.
                bus.o_media        <= soma_q[SomaW-1 -: DATA_WIDTH];
                bus.o_janela_cheia <= (estado_q == CHEIO);
            end
        end
    end

endmodule

// File: tb/tb_moving_average_filter.sv
// Directed bench for moving_average_filter with N = 4.
// Table rows give per-cycle stimulus and the outputs expected in that same cycle.
module tb_moving_average_filter;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       ev;
        logic [7:0] em;
        logic       ec;
    } vec_t;

    logic clk_fpga = 1'b0;
    logic reset_n  = 1'b0;
    int   n_vec    = 0;
    int   n_err    = 0;
    vec_t tbl[$];

    moving_average_filter_if #(.DATA_WIDTH(8)) bus ();

    moving_average_filter #(
        .DATA_WIDTH  (8),
        .LOG2_JANELA (2)
    ) dut (
        .clk_fpga (clk_fpga),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 clk_fpga = ~clk_fpga;

    task automatic add(input logic v, input logic [7:0] d, input logic l,
                       input logic ev, input logic [7:0] em, input logic ec);
        vec_t r;
        r.v = v; r.d = d; r.l = l; r.ev = ev; r.em = em; r.ec = ec;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic ev, input logic [7:0] em, input logic ec);
        n_vec++;
        if (bus.o_media_valida !== ev || bus.o_media !== em || bus.o_janela_cheia !== ec) begin
            n_err++;
            $display("FAIL %s: got valida=%b media=%0d cheia=%b, want valida=%b media=%0d cheia=%b",
                     name, bus.o_media_valida, bus.o_media, bus.o_janela_cheia, ev, em, ec);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic l);
        bus.i_dado_valido = v;
        bus.i_dado        = d;
        bus.i_limpar      = l;
    endtask

    initial begin
        // Warm-up 40 x4
        add(1, 40, 0, 0,  0, 0);
        add(1, 40, 0, 0,  0, 0);
        add(1, 40, 0, 1, 10, 0);
        add(1, 40, 0, 1, 20, 0);
        add(0,  0, 0, 1, 30, 0);
        add(0,  0, 0, 1, 40, 1);
        // Slide with gaps: 80 x4 then 0
        add(1, 80, 0, 0, 40, 1);
        add(0,  0, 0, 0, 40, 1);
        add(1, 80, 0, 1, 50, 1);
        add(0,  0, 0, 0, 50, 1);
        add(1, 80, 0, 1, 60, 1);
        add(0,  0, 0, 0, 60, 1);
        add(1, 80, 0, 1, 70, 1);
        add(0,  0, 0, 0, 70, 1);
        add(1,  0, 0, 1, 80, 1);
        add(0,  0, 0, 0, 80, 1);
        add(0,  0, 0, 1, 60, 1);
        add(0,  0, 1, 0, 60, 1);
        // 255 x4 after clear
        add(1, 255, 0, 0,   0, 0);
        add(1, 255, 0, 0,   0, 0);
        add(1, 255, 0, 1,  63, 0);
        add(1, 255, 0, 1, 127, 0);
        add(0,   0, 0, 1, 191, 0);
        add(0,   0, 1, 1, 255, 1);
        // Truncation: 1 x4
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 0, 1, 0, 0);
        add(1, 1, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0);
        add(0, 0, 0, 1, 1, 1);
        // Clear collides with sample 200
        add(1, 200, 1, 0,  1, 1);
        add(0,   0, 0, 0,  0, 0);
        add(1,  40, 0, 0,  0, 0);
        add(0,   0, 0, 0,  0, 0);
        add(0,   0, 0, 1, 10, 0);
        // Clear kills a sample still in flight
        add(1, 40, 0, 0, 10, 0);
        add(0,  0, 1, 0, 10, 0);
        add(0,  0, 0, 0,  0, 0);
        add(0,  0, 0, 0,  0, 0);

        drive(0, 0, 0);

        // Reset held with stimulus toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_fpga);
            chk($sformatf("reset_hold_%0d", i), 0, 0, 0);
            drive(1'(i % 2), 8'($urandom), 1'(i == 2));
        end
        @(negedge clk_fpga);
        reset_n = 1'b1;
        drive(0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_fpga);
            chk($sformatf("post_reset_idle_%0d", i), 0, 0, 0);
        end

        foreach (tbl[i]) begin
            @(negedge clk_fpga);
            chk($sformatf("row_%0d", i), tbl[i].ev, tbl[i].em, tbl[i].ec);
            drive(tbl[i].v, tbl[i].d, tbl[i].l);
        end

        // Back-to-back burst interrupted by async reset
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_fpga);
            case (k)
                2:       chk("burst_2", 1, 10, 0);
                3:       chk("burst_3", 1, 20, 0);
                default: chk($sformatf("burst_%0d", k), 0, 0, 0);
            endcase
            drive(1, 40, 0);
        end
        #2;
        reset_n = 1'b0;
        drive(0, 0, 0);
        #1;
        chk("async_reset_immediate", 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_fpga);
            chk($sformatf("async_reset_hold_%0d", i), 0, 0, 0);
        end
        reset_n = 1'b1;
        drive(1, 40, 0);
        @(negedge clk_fpga);
        chk("after_reset_0", 0, 0, 0);
        drive(0, 0, 0);
        @(negedge clk_fpga);
        chk("after_reset_40", 1, 10, 0);
        @(negedge clk_fpga);
        chk("after_reset_hold", 0, 10, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/moving_average_filter.md
# moving_average_filter

Streaming moving-average stage that consumes the validated byte stream produced by the handshake receiver (data bus plus one-cycle "new data ready" strobe). It keeps a sliding window of the last 2^LOG2_JANELA samples and emits the window average with its own one-cycle valid strobe. It is the first processing stage of the filter core, and its output feeds the result path toward the host.

## Interface
- DATA_WIDTH, 8: sample and average width, unsigned.
- LOG2_JANELA, 2: log2 of window size N; legal range 0..4 (N = 1..16).
- clk_fpga  input  1  single system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset; deassertion is synchronous to clk_fpga upstream.
- i_dado  input  DATA_WIDTH  sample; valid only while i_dado_valido = 1.
- i_dado_valido  input  1  one-cycle strobe per sample; may be high in consecutive cycles.
- i_limpar  input  1  synchronous clear of window, sum and state.
- o_media  output  DATA_WIDTH  window average, held between strobes.
- o_media_valida  output  1  one-cycle strobe, one per accepted sample.
- o_janela_cheia  output  1  1 when o_media was computed from N real samples.

## Operation
- Window: circular buffer of N entries of DATA_WIDTH. Write pointer ptr is LOG2_JANELA bits and wraps N-1 -> 0. Buffer entries are 0 after reset or clear.
- Running sum: soma is DATA_WIDTH+LOG2_JANELA bits.
  - On an accepted sample: soma <= soma + i_dado - buf[ptr]; buf[ptr] <= i_dado; ptr <= ptr+1.
  - Subtraction happens before the entry is overwritten. The sum never overflows or underflows.
- Average: o_media = soma >> LOG2_JANELA, truncating toward zero with no rounding. During warm-up the empty slots count as zero, so the divisor is always N.
- Sample counter cnt runs 0..N and saturates at N.
- State machine (estado_t):
  - VAZIO: cnt = 0.
  - ENCHENDO: 0 < cnt < N.
  - CHEIO: cnt = N.
- Transitions:
  - VAZIO -> ENCHENDO on the first sample, or VAZIO -> CHEIO when N = 1.
  - ENCHENDO -> CHEIO on the sample that makes cnt = N.
  - CHEIO stays in CHEIO on further samples.
  - Any state -> VAZIO on i_limpar.
- o_janela_cheia is registered together with o_media. It equals 1 iff the state after that sample's update is CHEIO.
- i_limpar:
  - In the cycle after it is seen: buffer, soma, cnt and ptr are zeroed; o_media = 0; o_janela_cheia = 0; o_media_valida = 0.
  - It has priority over a simultaneous i_dado_valido; that sample is discarded and produces no strobe.
  - A result already in the output register is suppressed.
- Reset values: o_media = 0, o_media_valida = 0, o_janela_cheia = 0, state VAZIO, buffer/soma/cnt/ptr = 0.

## Timing
- Two-stage pipeline:
  - Stage 1 (window/sum/state) updates at the edge that samples i_dado_valido = 1 (end of cycle k).
  - Stage 2 registers o_media, o_janela_cheia and o_media_valida at the next edge.
  - The strobe is high in cycle k+2: latency is 2 clocks.
- Throughput is one sample per clock. Back-to-back strobes give back-to-back o_media_valida with no gaps or bubbles.
- There is no backpressure. The downstream stage must accept every strobe.
- o_media and o_janela_cheia hold their values until the next strobe or clear.
- reset_n asserted mid-stream: all outputs go to reset values immediately, not waiting for a clock edge. Pending pipeline data is lost.

## Structure
- Package filtro_pkg holds:
  - estado_t enum {VAZIO, ENCHENDO, CHEIO}, logic [1:0].
  - Function largura_soma(dw, l2) returning dw+l2.
  - Legal-range constants for LOG2_JANELA.
- Sub-module janela_circular (DATA_WIDTH, LOG2_JANELA):
  - Contains the buffer and ptr, with write enable and clear inputs.
  - Outputs the oldest entry buf[ptr] combinationally.
- The top level holds soma, cnt, the FSM and the output register.
- A parameter assertion fires at elaboration if LOG2_JANELA is outside 0..4.

## Test plan
- Reset: hold reset_n = 0 with stimulus toggling -> all outputs 0 and no strobe. After release with no input -> still 0.
- Warm-up (N = 4): send 40,40,40,40 on consecutive cycles -> o_media = 10,20,30,40 in cycles k+2..k+5; o_janela_cheia = 0,0,0,1.
- Wrap and slide (N = 4): after the warm-up above, send 80,80,80,80,0 with gaps -> 50,60,70,80,60. ptr wraps twice.
- Extremes and truncation:
  - 255 x4 -> 255; soma = 1020 without overflow.
  - After a clear, 1,1,1 -> 0,0,0, then a fourth 1 -> 1.
- Clear collision: i_limpar and i_dado_valido (value 200) in the same cycle -> no strobe, all outputs 0. The next sample 40 -> 10 with o_janela_cheia = 0.
- Async reset mid-stream: assert reset_n between two strobes of a back-to-back burst -> outputs clear without a clock edge and no further strobe. After release, 40 -> 10.
